data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Word-organised data memory with a multi-cycle request/ready handshake.
- Sits directly downstream of the MIPS core's memory stage and services lw/sw at byte addresses (e.g. 1000, 2000, 2004).
- Adds fixed, parameterised access latency plus alignment and range checking, so the core's stall logic can be exercised under realistic wait states.

Parameters:
- DEPTH, 1024, number of 32-bit words; the valid byte address range is 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 2, wait states between request acceptance and ready (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = write (sw), 0 = read (lw); sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  write data; sampled with req.
- rdata  output  32  read data; updated only on a successful read completion, held otherwise.
- ready  output  1  one-cycle pulse marking completion of the accepted request.
- busy  output  1  high from the cycle after acceptance until and including the ready cycle.
- err  output  1  pulses with ready when the request was misaligned or out of range.

Behaviour:
- Reset values: rdata=0, ready=0, busy=0, err=0, FSM=IDLE, wait counter=0. Memory array contents are not cleared by reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE, req=1 at an edge:
  - latch addr, we, wdata;
  - load the counter with WAIT_CYCLES;
  - go to WAIT, or straight to DONE if WAIT_CYCLES=0.
- IDLE, req=0: stay in IDLE.
- WAIT: decrement the counter each cycle; when the counter reaches 1, go to DONE next edge.
- Total latency: ready is high exactly WAIT_CYCLES+1 cycles after the accepting edge.
- DONE (lasts one cycle):
  - ready=1; err=bad;
  - if we=1 and !bad, mem[addr[11:2]] <= wdata at the DONE edge;
  - if we=0 and !bad, rdata <= mem[addr[11:2]], visible while ready=1;
  - return to IDLE.
- bad = (latched addr[1:0] != 0) OR (latched addr >= 4*DEPTH).
  - On bad: no memory write, rdata unchanged, err=1 for the ready cycle only.
- req is ignored in WAIT and DONE. No queuing; the requester holds req until it sees ready.
  - If req is still high in the IDLE cycle after DONE, that is a new request, accepted at the next edge.
  - Throughput: one access per WAIT_CYCLES+2 cycles.
- Address decode uses only the latched address. Changes on addr/wdata/we after acceptance have no effect.
- Read-after-write to the same word, in the next request, returns the newly written value.
- Reset asserted mid-operation:
  - FSM returns to IDLE immediately (asynchronously) and all outputs take their reset values;
  - a pending write is dropped, with no partial write;
  - the request is not replayed after reset deasserts.
- Upper address bits above bit 11 (for DEPTH=1024) are range-checked, never silently aliased.

Test Plan:
- Write then read, WAIT_CYCLES=2: req, we=1, addr=2000, wdata=0x00000050 -> ready exactly 3 cycles after acceptance, err=0. Then read addr=2000 -> rdata=0x00000050 on the ready cycle.
- Misaligned access: read addr=1001 -> ready+err pulse together, rdata unchanged. Then write addr=1002, wdata=0xDEADBEEF -> err=1; a follow-up read of 1000 returns its prior value.
- Out of range: write addr=4096, wdata=0x12345678 -> err=1, no write. Word 0 and word 1023 (addr 0, 4092) are unchanged on readback.
- Back-to-back, req held high: write 2004=0x000003E8, then read 2004 -> second ready exactly WAIT_CYCLES+2 cycles after the first, rdata=0x000003E8. The busy pulse ends on each ready cycle.
- Reset mid-write: accept write addr=1000, wdata=0xFFFFFFFF over a prior value of 0x00000007; assert rst in WAIT for 1 cycle -> ready/busy/err=0 immediately; no ready pulse for that request; a later read of 1000 returns 0x00000007.
- WAIT_CYCLES=0 build: write then read addr=8, value 0xA5A5A5A5 -> ready one cycle after each acceptance, correct readback. Requests asserted during busy are ignored, with no extra ready pulse.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory behind a req/ready handshake: ready pulses WAIT_CYCLES+1 cycles after the accepting edge.
// No queuing: req is only sampled in IDLE, so the requester holds req until ready; misaligned/out-of-range accesses complete with err.
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] ADDR_LIM = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem_rd;
  logic             mem_wr;
  logic             bad;
  logic             rd_hit;

  // The full 32-bit latched address is range-checked so high bits never alias into the array.
  always_comb begin
    bad      = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIM);
    word_idx = addr_q[IDX_W+1:2];
    mem_rd   = mem_q[word_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!bad) begin
          if (we_q) begin
            mem_wr = 1'b1;
          end else begin
            rdata_d = mem_rd;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately not reset; a reset only ever cancels a write because mem_wr needs ST_DONE.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  // Read data is forwarded combinationally during DONE so it is visible alongside ready.
  always_comb begin
    ready  = (state_q == ST_DONE);
    busy   = (state_q != ST_IDLE);
    err    = ready && bad;
    rd_hit = ready && !we_q && !bad;
    rdata  = rd_hit ? mem_rd : rdata_q;
  end

endmodule
